parity_frame_ctrl: RTL

- Serial frame receiver/controller built around the bit-serial parity accumulator.
- Sequences one frame: start bit, DATA_BITS data bits (LSB first), one parity bit, one stop bit.
- Accumulates parity and checks it against the received parity bit.
- Presents the assembled word with error flags to a downstream consumer over a valid/ready handshake.

---
 rtl/parity_frame_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/parity_frame_ctrl.sv
// -----------------------------------------------------------------------------
// parity_frame_ctrl
//
// Serial frame receiver. A frame is one start bit (0), DATA_BITS data bits
// sent LSB first, one parity bit and one stop bit (1). Only cycles with
// bit_valid high carry a bit. The data bits are collected into a word, their
// parity is checked against the received parity bit, and the word is offered
// downstream with its error flags over a valid/ready handshake.
//
// Parameters:
//   DATA_BITS   data bits per frame, 2..16
//   ODD_PARITY  0 = even parity expected, 1 = odd parity expected
//
// Ports:
//   clock          design clock, rising edge
//   reset          asynchronous reset, active low
//   bit_valid      input_bit carries a serial bit this cycle
//   input_bit      serial bit stream
//   abort          synchronous abort, drops the frame in progress
//   frame_ready    downstream can accept the frame
//   frame_valid    frame_data and error flags are valid
//   frame_data     received word, bit i = i-th data bit received
//   parity_error   parity bit mismatched (valid with frame_valid)
//   framing_error  stop bit was 0 (valid with frame_valid)
//   overrun        one-cycle pulse when a start bit is dropped while holding
//   busy           high whenever a frame is in progress or held
//   err_count      (only with PARITY_ERR_CNT_EN) saturating count of frames
//                  completed with a parity or framing error
//
// Optional feature macro: PARITY_ERR_CNT_EN adds the err_count output.
// -----------------------------------------------------------------------------
module parity_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 input_bit,
  input  logic                 abort,
  input  logic                 frame_ready,
  output logic                 frame_valid,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP,
    S_HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             acc;

  // A start bit is a qualified 0 seen while idle; a 1 is just the idle line.
  logic start_bit;
  assign start_bit = bit_valid && !input_bit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt is given a default before the case so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_bit)                   state_nxt = S_DATA;
      S_DATA: if (bit_valid && cnt == LAST_BIT) state_nxt = S_PAR;
      S_PAR:  if (bit_valid)                   state_nxt = S_STOP;
      S_STOP: if (bit_valid)                   state_nxt = S_HOLD;
      // Transfer leaves HOLD regardless of bit_valid; any bit arriving in the
      // same cycle is discarded, so a start bit cannot slip in here.
      S_HOLD: if (frame_ready)                 state_nxt = S_IDLE;
      default:                                 state_nxt = S_IDLE;
    endcase
    // Abort wins over everything; a coinciding transfer also lands in IDLE,
    // so it still counts as delivered.
    if (abort) state_nxt = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath: bit counter, parity accumulator, received word and flags
  // ---------------------------------------------------------------------------
  // NOTE: frame_data is a plain register word, not a memory, so it takes the
  // asynchronous reset like the rest of the state and reads 0 after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      acc           <= ODD_PARITY;
      frame_data    <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // Every qualified 0 while holding is a start bit that gets dropped.
      overrun <= (state == S_HOLD) && start_bit;

      if (abort) begin
        // frame_data is intentionally left as is.
        cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_bit) begin
              cnt           <= '0;
              acc           <= ODD_PARITY;
              parity_error  <= 1'b0;
              framing_error <= 1'b0;
            end
          end
          S_DATA: begin
            if (bit_valid) begin
              frame_data[cnt] <= input_bit;
              acc             <= acc ^ input_bit;
              // Counter parks on the last index instead of wrapping.
              if (cnt != LAST_BIT) cnt <= cnt + 1'b1;
            end
          end
          S_PAR: begin
            // acc was seeded with ODD_PARITY, so a correct parity bit makes
            // the total zero for either parity sense.
            if (bit_valid) parity_error <= acc ^ input_bit;
          end
          S_STOP: begin
            if (bit_valid) framing_error <= ~input_bit;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // ---------------------------------------------------------------------------
  // Error frame counter: counts frames entering HOLD with either error.
  // The parity flag is already registered by the stop-bit edge; the framing
  // result is taken straight from the stop bit being sampled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (state == S_STOP && bit_valid && !abort &&
                 (parity_error || !input_bit) && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

  assign frame_valid = (state == S_HOLD);
  assign busy        = (state != S_IDLE);

endmodule
